// File: rtl/sine_sweep_master.sv
// sine_sweep_master
//   Purpose : Avalon-MM style initiator that sweeps the frequency step of a
//             sine generator peripheral, samples its output register during
//             each dwell and reports the peak sample seen per step.
//   Ports   : Clk/Reset (async, active-high); Start (pulse) / Stop (abort);
//             bus side ChipSelect/Write/Read/Address/WriteData/ReadData
//             (zero-wait slave, ReadData valid the cycle after Read);
//             status Busy, PeakValid/PeakStep/PeakSample, Done.
//   Config  : define SINE_SWEEP_LOOP_EN to make the sweep wrap back to
//             STEP_START indefinitely (until Stop) instead of finishing once.
module sine_sweep_master #(
  parameter logic [31:0] STEP_START    = 32'd16,
  parameter logic [31:0] STEP_END      = 32'd48,
  parameter logic [31:0] STEP_INC      = 32'd16,
  parameter int unsigned DWELL_CYCLES  = 64,
  parameter int unsigned READ_INTERVAL = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stop,
  output logic        ChipSelect,
  output logic        Write,
  output logic        Read,
  output logic [1:0]  Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  output logic        Busy,
  output logic        PeakValid,
  output logic [31:0] PeakStep,
  output logic [9:0]  PeakSample,
  output logic        Done
);

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] INTV_LAST  = 32'(READ_INTERVAL - 1);

  localparam logic [1:0] ADDR_STEP   = 2'd0;
  localparam logic [1:0] ADDR_ENABLE = 2'd1;
  localparam logic [1:0] ADDR_SAMPLE = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_STEP = 4'd1,
    S_WR_EN   = 4'd2,
    S_DWELL   = 4'd3,
    S_RD      = 4'd4,
    S_RD_CAP  = 4'd5,
    S_NEXT    = 4'd6,
    S_WR_DIS  = 4'd7,
    S_DONE    = 4'd8
  } state_e;

  state_e      state_q, state_d;

  logic [31:0] step_q, step_d;
  logic [31:0] dwell_q, dwell_d;
  logic [31:0] intv_q, intv_d;
  logic [9:0]  peak_q, peak_d;
  logic        first_q, first_d;
  logic        abort_q, abort_d;
  logic [31:0] pk_step_q, pk_step_d;
  logic [9:0]  pk_samp_q, pk_samp_d;

  // Only the low 10 bits of the sample register carry data.
  logic        unused_rdata;
  assign unused_rdata = ^ReadData[31:10];

  logic [9:0]  sample;
  assign sample = ReadData[9:0];

  // 33-bit add so a step near 2^32 cannot wrap back into range.
  logic [32:0] step_sum;
  logic        step_over;
  assign step_sum  = {1'b0, step_q} + {1'b0, STEP_INC};
  assign step_over = step_sum[32] || (step_sum[31:0] > STEP_END);

  logic dwell_last;     // exact expiry cycle, used while in DWELL
  logic dwell_expired;  // expiry reached during RD or RD_CAP (counter may be one past)
  logic intv_last;
  assign dwell_last    = (dwell_q == DWELL_LAST);
  assign dwell_expired = (dwell_q >= DWELL_LAST);
  assign intv_last     = (intv_q == INTV_LAST);

  // Abort takes effect in the cycle Stop is seen as well as from the flag.
  logic abort_now;
  assign abort_now = abort_q || Stop;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start && !Stop) state_d = S_WR_STEP;
      end
      S_WR_STEP: begin
        if (abort_now)    state_d = S_WR_DIS;
        else if (first_q) state_d = S_WR_EN;
        else              state_d = S_DWELL;
      end
      S_WR_EN: begin
        state_d = abort_now ? S_WR_DIS : S_DWELL;
      end
      S_DWELL: begin
        if (abort_now)       state_d = S_WR_DIS;
        else if (dwell_last) state_d = S_NEXT;
        else if (intv_last)  state_d = S_RD;
        else                 state_d = S_DWELL;
      end
      // A read in flight always completes its capture, even when aborting.
      S_RD: begin
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        if (abort_now)          state_d = S_WR_DIS;
        else if (dwell_expired) state_d = S_NEXT;
        else                    state_d = S_DWELL;
      end
      S_NEXT: begin
        if (abort_now) begin
          state_d = S_WR_DIS;
        end else if (step_over) begin
`ifdef SINE_SWEEP_LOOP_EN
          state_d = S_WR_STEP;
`else
          state_d = S_WR_DIS;
`endif
        end else begin
          state_d = S_WR_STEP;
        end
      end
      S_WR_DIS: begin
        state_d = abort_q ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next-state: step, counters, peak tracking, flags
  // ---------------------------------------------------------------------
  always_comb begin
    step_d    = step_q;
    dwell_d   = dwell_q;
    intv_d    = intv_q;
    peak_d    = peak_q;
    first_d   = first_q;
    abort_d   = abort_q;
    pk_step_d = pk_step_q;
    pk_samp_d = pk_samp_q;

    case (state_q)
      S_IDLE: begin
        first_d = 1'b1;
        abort_d = 1'b0;
      end
      S_WR_STEP: begin
        first_d = 1'b0;
      end
      S_DWELL: begin
        dwell_d = dwell_q + 32'd1;
        intv_d  = intv_last ? 32'd0 : intv_q + 32'd1;
      end
      S_RD: begin
        dwell_d = dwell_q + 32'd1;
      end
      S_RD_CAP: begin
        dwell_d = dwell_q + 32'd1;
        if (sample > peak_q) peak_d = sample;
      end
      S_NEXT: begin
        peak_d = 10'd0;
`ifdef SINE_SWEEP_LOOP_EN
        step_d = step_over ? STEP_START : step_sum[31:0];
`else
        step_d = step_sum[31:0];
`endif
      end
      S_WR_DIS: begin
        if (abort_q) step_d = STEP_START;
        abort_d = 1'b0;
      end
      S_DONE: begin
        step_d = STEP_START;
      end
      default: begin
      end
    endcase

    // Stop is latched in every busy state except the closing WR_DIS/DONE.
    if (Stop && (state_q != S_IDLE) && (state_q != S_WR_DIS) && (state_q != S_DONE)) begin
      abort_d = 1'b1;
    end

    // Each dwell starts with fresh counters.
    if ((state_d == S_WR_STEP) && (state_q != S_WR_STEP)) begin
      dwell_d = 32'd0;
      intv_d  = 32'd0;
    end

    // Result registers load on entry to NEXT so they are valid alongside
    // PeakValid; peak_d already includes a capture in the same cycle.
    if ((state_d == S_NEXT) && (state_q != S_NEXT)) begin
      pk_step_d = step_q;
      pk_samp_d = peak_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      step_q    <= STEP_START;
      dwell_q   <= 32'd0;
      intv_q    <= 32'd0;
      peak_q    <= 10'd0;
      first_q   <= 1'b0;
      abort_q   <= 1'b0;
      pk_step_q <= 32'd0;
      pk_samp_q <= 10'd0;
    end else begin
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      intv_q    <= intv_d;
      peak_q    <= peak_d;
      first_q   <= first_d;
      abort_q   <= abort_d;
      pk_step_q <= pk_step_d;
      pk_samp_q <= pk_samp_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from the state register (Moore)
  // ---------------------------------------------------------------------
  always_comb begin
    ChipSelect = 1'b0;
    Write      = 1'b0;
    Read       = 1'b0;
    Address    = ADDR_STEP;
    WriteData  = 32'd0;
    Busy       = (state_q != S_IDLE);
    PeakValid  = 1'b0;
    Done       = 1'b0;
    case (state_q)
      S_WR_STEP: begin
        ChipSelect = 1'b1;
        Write      = 1'b1;
        Address    = ADDR_STEP;
        WriteData  = step_q;
      end
      S_WR_EN: begin
        ChipSelect = 1'b1;
        Write      = 1'b1;
        Address    = ADDR_ENABLE;
        WriteData  = 32'd1;
      end
      S_RD: begin
        ChipSelect = 1'b1;
        Read       = 1'b1;
        Address    = ADDR_SAMPLE;
      end
      S_NEXT: begin
        PeakValid = 1'b1;
      end
      S_WR_DIS: begin
        ChipSelect = 1'b1;
        Write      = 1'b1;
        Address    = ADDR_ENABLE;
        WriteData  = 32'd0;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign PeakStep   = pk_step_q;
  assign PeakSample = pk_samp_q;

endmodule

// File: tb/tb_sine_sweep_master.sv
// tb_sine_sweep_master
//   Directed bench for sine_sweep_master: a zero-wait slave model answers
//   reads from a preloaded queue, a negedge monitor logs bus writes, reads,
//   PeakValid and Done events, and expected values are fixed constants.
module tb_sine_sweep_master;

`ifdef SINE_SWEEP_LOOP_EN
  localparam logic [31:0] TB_STEP_END = 32'd32;
`else
  localparam logic [31:0] TB_STEP_END = 32'd48;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Stop;
  logic        ChipSelect;
  logic        Write;
  logic        Read;
  logic [1:0]  Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData = 32'd0;
  logic        Busy;
  logic        PeakValid;
  logic [31:0] PeakStep;
  logic [9:0]  PeakSample;
  logic        Done;

  sine_sweep_master #(
    .STEP_START   (32'd16),
    .STEP_END     (TB_STEP_END),
    .STEP_INC     (32'd16),
    .DWELL_CYCLES (64),
    .READ_INTERVAL(8)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Stop      (Stop),
    .ChipSelect(ChipSelect),
    .Write     (Write),
    .Read      (Read),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Busy      (Busy),
    .PeakValid (PeakValid),
    .PeakStep  (PeakStep),
    .PeakSample(PeakSample),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // ---------------------------------------------------------------------
  // Monitor + zero-wait slave (samples on the falling edge)
  // ---------------------------------------------------------------------
  int          cyc = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          rd_cyc[$];
  logic [31:0] rd_vals[$];
  logic [31:0] pv_step[$];
  logic [31:0] pv_samp[$];
  int          pv_cyc[$];
  int          done_cnt = 0;

  always @(negedge Clk) begin
    cyc++;
    if (ChipSelect && Write) begin
      wr_addr.push_back(32'(Address));
      wr_data.push_back(WriteData);
      wr_cyc.push_back(cyc);
    end
    if (ChipSelect && Read) begin
      rd_cyc.push_back(cyc);
      // Held through the following cycle, where the DUT captures it.
      if (rd_vals.size() > 0) ReadData = rd_vals.pop_front();
      else                    ReadData = 32'd0;
    end
    if (PeakValid) begin
      pv_step.push_back(PeakStep);
      pv_samp.push_back(32'(PeakSample));
      pv_cyc.push_back(cyc);
    end
    if (Done) done_cnt++;
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); rd_cyc.delete();
    rd_vals.delete(); pv_step.delete(); pv_samp.delete(); pv_cyc.delete();
    done_cnt = 0;
  endtask

  // Six reads per dwell; per-dwell maxima of [9:0] are 900, 50 and 5
  // (0x405 carries data above bit 9 that must be ignored).
  task automatic load_reads();
    logic [31:0] v [18] = '{32'd100, 32'd900, 32'd300, 32'd0, 32'd0, 32'd0,
                            32'd50,  32'd10,  32'd20,  32'd0, 32'd0, 32'd0,
                            32'h405, 32'd3,   32'd2,   32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 18; i++) rd_vals.push_back(v[i]);
  endtask

  task automatic pulse_start();
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(negedge Clk);
    check_eq({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    repeat (2) @(negedge Clk);
    check_eq({tag, "_busy_after"}, 32'(Busy), 32'd0);
  endtask

  // Full default sweep: steps 16/32/48, peaks 900/50/5, one enable and one disable.
  task automatic check_sweep(input string tag);
    logic [31:0] ea [5] = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
    logic [31:0] ed [5] = '{32'd16, 32'd1, 32'd32, 32'd48, 32'd0};
    logic [31:0] es [3] = '{32'd900, 32'd50, 32'd5};
    check_eq({tag, "_wr_count"}, 32'(wr_addr.size()), 32'd5);
    check_eq({tag, "_rd_count"}, 32'(rd_cyc.size()), 32'd18);
    check_eq({tag, "_pv_count"}, 32'(pv_step.size()), 32'd3);
    if (wr_addr.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check_eq($sformatf("%s_wr%0d_addr", tag, i), wr_addr[i], ea[i]);
        check_eq($sformatf("%s_wr%0d_data", tag, i), wr_data[i], ed[i]);
      end
    end
    if (pv_step.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("%s_pv%0d_step", tag, i), pv_step[i], 32'(16 + 16 * i));
        check_eq($sformatf("%s_pv%0d_samp", tag, i), pv_samp[i], es[i]);
      end
    end
    if (wr_cyc.size() >= 3 && rd_cyc.size() >= 2 && pv_cyc.size() >= 1) begin
      check_eq({tag, "_first_rd_lat"}, 32'(rd_cyc[0] - wr_cyc[0]), 32'd10);
      check_eq({tag, "_rd_spacing"},   32'(rd_cyc[1] - rd_cyc[0]), 32'd10);
      check_eq({tag, "_pv_lat"},       32'(pv_cyc[0] - wr_cyc[0]), 32'd66);
      check_eq({tag, "_step2_lat"},    32'(wr_cyc[2] - wr_cyc[0]), 32'd67);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr;
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("rst_ctrl_in_reset", 32'({ChipSelect, Write, Read, Address, Busy, PeakValid, Done}), 32'd0);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check_eq("rst_ctrl", 32'({ChipSelect, Write, Read, Address, Busy, PeakValid, Done}), 32'd0);
    check_eq("rst_wdata", WriteData, 32'd0);
    check_eq("rst_peak_step", PeakStep, 32'd0);
    check_eq("rst_peak_samp", 32'(PeakSample), 32'd0);

`ifndef SINE_SWEEP_LOOP_EN
    // Sweep 1: Start held high for most of the sweep must not restart it.
    clear_log();
    load_reads();
    @(posedge Clk); #1 Start = 1'b1;
    repeat (100) @(posedge Clk);
    #1 Start = 1'b0;
    wait_done("sweep1");
    check_sweep("sweep1");

    // Abort: Stop during the second RD; capture completes, then disable, no results.
    clear_log();
    load_reads();
    pulse_start();
    nr = 0;
    for (int i = 0; i < 200 && nr < 2; i++) begin
      @(negedge Clk);
      if (Read) nr++;
    end
    check_eq("abort_reached_rd", 32'(nr), 32'd2);
    Stop = 1'b1;
    @(negedge Clk);
    Stop = 1'b0;
    repeat (6) @(negedge Clk);
    check_eq("abort_wr_count", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3 && rd_cyc.size() == 2) begin
      check_eq("abort_dis_addr", wr_addr[2], 32'd1);
      check_eq("abort_dis_data", wr_data[2], 32'd0);
      check_eq("abort_dis_lat", 32'(wr_cyc[2] - rd_cyc[1]), 32'd2);
    end
    check_eq("abort_pv_count", 32'(pv_step.size()), 32'd0);
    check_eq("abort_done_count", 32'(done_cnt), 32'd0);
    check_eq("abort_busy", 32'(Busy), 32'd0);

    // Restart after abort begins again at step 16.
    clear_log();
    load_reads();
    pulse_start();
    wait_done("restart");
    check_sweep("restart");

    // Start and Stop together in IDLE: Stop wins.
    clear_log();
    @(posedge Clk); #1 begin Start = 1'b1; Stop = 1'b1; end
    @(posedge Clk); #1 begin Start = 1'b0; Stop = 1'b0; end
    @(negedge Clk);
    check_eq("startstop_busy", 32'(Busy), 32'd0);
    repeat (5) @(negedge Clk);
    check_eq("startstop_wr_count", 32'(wr_addr.size()), 32'd0);

    // Reset while the enable write is on the bus: outputs drop immediately.
    clear_log();
    pulse_start();
    nr = 0;
    for (int i = 0; i < 20 && nr == 0; i++) begin
      @(negedge Clk);
      if (ChipSelect && Write && Address == 2'd1) nr = 1;
    end
    check_eq("rstmid_saw_wr_en", 32'(nr), 32'd1);
    #1 Reset = 1'b1;
    #1 check_eq("rstmid_ctrl", 32'({ChipSelect, Write, Read, Busy}), 32'd0);
    @(negedge Clk); #1 Reset = 1'b0;
    clear_log();
    load_reads();
    pulse_start();
    wait_done("after_rst");
    check_sweep("after_rst");
`else
    // Looping sweep: steps wrap 16, 32, 16, 32 with no disable until Stop.
    clear_log();
    pulse_start();
    for (int i = 0; i < 600 && pv_step.size() < 4; i++) @(negedge Clk);
    check_eq("loop_pv_count", 32'(pv_step.size() >= 4), 32'd1);
    if (pv_step.size() >= 4) begin
      check_eq("loop_pv0", pv_step[0], 32'd16);
      check_eq("loop_pv1", pv_step[1], 32'd32);
      check_eq("loop_pv2", pv_step[2], 32'd16);
      check_eq("loop_pv3", pv_step[3], 32'd32);
    end
    nr = 0;
    foreach (wr_addr[i]) if (wr_addr[i] == 32'd1 && wr_data[i] == 32'd0) nr++;
    check_eq("loop_no_dis_before_stop", 32'(nr), 32'd0);
    if (wr_addr.size() >= 4) begin
      check_eq("loop_wrap_addr", wr_addr[3], 32'd0);
      check_eq("loop_wrap_data", wr_data[3], 32'd16);
    end
    @(posedge Clk); #1 Stop = 1'b1;
    @(posedge Clk); #1 Stop = 1'b0;
    repeat (10) @(negedge Clk);
    check_eq("loop_busy_after_stop", 32'(Busy), 32'd0);
    check_eq("loop_done_count", 32'(done_cnt), 32'd0);
    if (wr_addr.size() > 0) begin
      check_eq("loop_last_addr", wr_addr[wr_addr.size() - 1], 32'd1);
      check_eq("loop_last_data", wr_data[wr_data.size() - 1], 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
